// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control FSM: opcode/funct
// values, state encodings, ALU control codes, mux select encodings and the
// control-word struct carried between the decode logic and the output registers.
package mc_ctrl_pkg;

    // Opcodes (instruction[31:26])
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_J    = 6'b000010;

    // R-type funct codes (instruction[5:0])
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    // Native ALU control codes; the top zero-extends to ALU_CTRL_W
    localparam int         ALU_W   = 3;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // alu_src_b selects
    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    // pc_src selects
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // State encodings; 14 and 15 are unreachable
    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_MEMADR = 4'd3,
        ST_MEMRD  = 4'd4,
        ST_MEMWB  = 4'd5,
        ST_MEMWR  = 4'd6,
        ST_EXEC   = 4'd7,
        ST_ALUWB  = 4'd8,
        ST_IEXEC  = 4'd9,
        ST_IWB    = 4'd10,
        ST_BEQ    = 4'd11,
        ST_BNE    = 4'd12,
        ST_JUMP   = 4'd13
    } state_t;

    // Registered control word (everything except illegal)
    typedef struct packed {
        logic             reg_write;
        logic             alu_src_a;
        logic [1:0]       alu_src_b;
        logic [ALU_W-1:0] alu_ctrl;
        logic [1:0]       pc_src;
        logic             pc_write;
        logic             branch;
        logic             branch_ne;
        logic             iord;
        logic             mem_write;
        logic             ir_write;
        logic             reg_dst;
        logic             mem_to_reg;
        logic             imm_zext;
    } ctrl_t;

    // True for encodings the FSM can actually occupy
    function automatic logic state_legal(input state_t s);
        return (s <= ST_JUMP);
    endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// Combinational ALU decoder: R-type funct or I-type ALU opcode -> alu_ctrl,
// imm_zext and an invalid flag. Unknown encodings yield alu_ctrl=0.
import mc_ctrl_pkg::*;

module mc_alu_decoder (
    input  logic [5:0]       i_op,
    input  logic [5:0]       i_funct,
    output logic [ALU_W-1:0] o_alu_ctrl,
    output logic             o_imm_zext,
    output logic             o_invalid
);

    // R-type decodes funct; everything else is treated as an immediate ALU op
    always_comb begin
        o_alu_ctrl = '0;
        o_imm_zext = 1'b0;
        o_invalid  = 1'b0;
        if (i_op == OP_R) begin
            case (i_funct)
                FN_ADD:  o_alu_ctrl = ALU_ADD;
                FN_SUB:  o_alu_ctrl = ALU_SUB;
                FN_AND:  o_alu_ctrl = ALU_AND;
                FN_OR:   o_alu_ctrl = ALU_OR;
                FN_SLT:  o_alu_ctrl = ALU_SLT;
                default: o_invalid  = 1'b1;
            endcase
        end else begin
            case (i_op)
                OP_ADDI: o_alu_ctrl = ALU_ADD;
                OP_ANDI: begin o_alu_ctrl = ALU_AND; o_imm_zext = 1'b1; end
                OP_ORI:  begin o_alu_ctrl = ALU_OR;  o_imm_zext = 1'b1; end
                default: o_invalid = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM. Control outputs are registered: the word for
// the state being entered is computed alongside the next state and loaded on
// the same edge. illegal and the memory-wait gating are the only combinational
// output terms.
// Optional feature: define MC_CTRL_MEM_WAIT_EN to add i_mem_ready and let
// FETCH/MEMRD/MEMWR stall until memory completes.
import mc_ctrl_pkg::*;

module mc_ctrl_fsm #(
    parameter int ALU_CTRL_W = 3,
    parameter int STATE_W    = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [5:0]            i_op,
    input  logic [5:0]            i_funct,
`ifdef MC_CTRL_MEM_WAIT_EN
    input  logic                  i_mem_ready,
`endif
    output logic                  o_reg_write,
    output logic                  o_alu_src_a,
    output logic [1:0]            o_alu_src_b,
    output logic [ALU_CTRL_W-1:0] o_alu_ctrl,
    output logic [1:0]            o_pc_src,
    output logic                  o_pc_write,
    output logic                  o_branch,
    output logic                  o_branch_ne,
    output logic                  o_iord,
    output logic                  o_mem_write,
    output logic                  o_ir_write,
    output logic                  o_reg_dst,
    output logic                  o_mem_to_reg,
    output logic                  o_imm_zext,
    output logic                  o_illegal,
    output logic [STATE_W-1:0]    o_state
);

    if (STATE_W < 4) begin : g_bad_state_w
        $error("mc_ctrl_fsm: STATE_W must be >= 4");
    end

    state_t           r_state;
    ctrl_t            r_out;
    state_t           w_next;
    ctrl_t            w_nout;
    ctrl_t            w_out;
    logic             w_illegal;
    logic             w_ready;
    logic             w_legal;
    logic [ALU_W-1:0] w_dec_alu;
    logic             w_dec_zext;
    logic             w_dec_invalid;

`ifdef MC_CTRL_MEM_WAIT_EN
    assign w_ready = i_mem_ready;
`else
    assign w_ready = 1'b1;
`endif

    // One decoder serves both EXEC (funct) and IEXEC (op); op/funct are
    // stable from DECODE, so its result is valid when loading those states.
    mc_alu_decoder u_alu_dec (
        .i_op       (i_op),
        .i_funct    (i_funct),
        .o_alu_ctrl (w_dec_alu),
        .o_imm_zext (w_dec_zext),
        .o_invalid  (w_dec_invalid)
    );

    // Next-state selection and control word for the state being entered
    always_comb begin
        w_next    = r_state;
        w_nout    = '0;
        w_illegal = 1'b0;

        case (r_state)
            ST_IDLE:   w_next = ST_FETCH;
            ST_FETCH:  w_next = w_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (i_op)
                    OP_R: begin
                        // Bad funct is caught here so the core never reaches
                        // a write-back state for it.
                        if (w_dec_invalid) begin
                            w_illegal = 1'b1;
                            w_next    = ST_FETCH;
                        end else begin
                            w_next    = ST_EXEC;
                        end
                    end
                    OP_LW, OP_SW:              w_next = ST_MEMADR;
                    OP_BEQ:                    w_next = ST_BEQ;
                    OP_BNE:                    w_next = ST_BNE;
                    OP_ADDI, OP_ANDI, OP_ORI:  w_next = ST_IEXEC;
                    OP_J:                      w_next = ST_JUMP;
                    default: begin
                        w_illegal = 1'b1;
                        w_next    = ST_FETCH;
                    end
                endcase
            end
            ST_MEMADR: w_next = (i_op == OP_LW) ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD:  w_next = w_ready ? ST_MEMWB : ST_MEMRD;
            ST_MEMWB:  w_next = ST_FETCH;
            ST_MEMWR:  w_next = w_ready ? ST_FETCH : ST_MEMWR;
            ST_EXEC: begin
                // Only reachable with a bad funct if funct changed after DECODE
                if (w_dec_invalid) begin
                    w_illegal = 1'b1;
                    w_next    = ST_FETCH;
                end else begin
                    w_next    = ST_ALUWB;
                end
            end
            ST_ALUWB:  w_next = ST_FETCH;
            ST_IEXEC:  w_next = ST_IWB;
            ST_IWB:    w_next = ST_FETCH;
            ST_BEQ:    w_next = ST_FETCH;
            ST_BNE:    w_next = ST_FETCH;
            ST_JUMP:   w_next = ST_FETCH;
            default:   w_next = ST_FETCH;
        endcase

        case (w_next)
            ST_FETCH: begin
                w_nout.alu_src_b = SRCB_FOUR;
                w_nout.alu_ctrl  = ALU_ADD;
                w_nout.pc_src    = PCSRC_ALU;
                w_nout.ir_write  = 1'b1;
                w_nout.pc_write  = 1'b1;
            end
            ST_DECODE: begin
                w_nout.alu_src_b = SRCB_IMMSH;
                w_nout.alu_ctrl  = ALU_ADD;
            end
            ST_MEMADR: begin
                w_nout.alu_src_a = 1'b1;
                w_nout.alu_src_b = SRCB_IMM;
                w_nout.alu_ctrl  = ALU_ADD;
            end
            ST_MEMRD:  w_nout.iord = 1'b1;
            ST_MEMWB: begin
                w_nout.mem_to_reg = 1'b1;
                w_nout.reg_write  = 1'b1;
            end
            ST_MEMWR: begin
                w_nout.iord      = 1'b1;
                w_nout.mem_write = 1'b1;
            end
            ST_EXEC: begin
                w_nout.alu_src_a = 1'b1;
                w_nout.alu_src_b = SRCB_REGB;
                w_nout.alu_ctrl  = w_dec_alu;
            end
            ST_ALUWB: begin
                w_nout.reg_dst   = 1'b1;
                w_nout.reg_write = 1'b1;
            end
            ST_IEXEC: begin
                w_nout.alu_src_a = 1'b1;
                w_nout.alu_src_b = SRCB_IMM;
                w_nout.alu_ctrl  = w_dec_alu;
                w_nout.imm_zext  = w_dec_zext;
            end
            ST_IWB: begin
                w_nout.reg_write = 1'b1;
                w_nout.imm_zext  = w_dec_zext;
            end
            ST_BEQ, ST_BNE: begin
                w_nout.alu_src_a = 1'b1;
                w_nout.alu_src_b = SRCB_REGB;
                w_nout.alu_ctrl  = ALU_SUB;
                w_nout.pc_src    = PCSRC_ALUOUT;
                w_nout.branch    = (w_next == ST_BEQ);
                w_nout.branch_ne = (w_next == ST_BNE);
            end
            ST_JUMP: begin
                w_nout.pc_src   = PCSRC_JUMP;
                w_nout.pc_write = 1'b1;
            end
            default: w_nout = '0;
        endcase
    end

    // State and registered control word; reset drops any pending write at once
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_out   <= '0;
        end else begin
            r_state <= w_next;
            r_out   <= w_nout;
        end
    end

    // Outputs are forced to 0 if the state register ever holds a bad encoding
    assign w_legal = state_legal(r_state);
    assign w_out   = w_legal ? r_out : '0;

    assign o_reg_write  = w_out.reg_write;
    assign o_alu_src_a  = w_out.alu_src_a;
    assign o_alu_src_b  = w_out.alu_src_b;
    assign o_alu_ctrl   = ALU_CTRL_W'(w_out.alu_ctrl);
    assign o_pc_src     = w_out.pc_src;
    assign o_branch     = w_out.branch;
    assign o_branch_ne  = w_out.branch_ne;
    assign o_iord       = w_out.iord;
    assign o_reg_dst    = w_out.reg_dst;
    assign o_mem_to_reg = w_out.mem_to_reg;
    assign o_imm_zext   = w_out.imm_zext;
    // Memory-side strobes fire only on the cycle the access completes
    assign o_ir_write   = w_out.ir_write  & w_ready;
    assign o_pc_write   = w_out.pc_write  & (w_ready | (r_state == ST_JUMP));
    assign o_mem_write  = w_out.mem_write & w_ready;
    assign o_illegal    = w_illegal;
    assign o_state      = STATE_W'(r_state);

endmodule
